// File: rtl/param_mem_pkg.sv
// Shared types, opcodes and the parity helper for the parametrised memory controller.
package param_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Words wider than this are truncated before parity is computed.
    localparam int PAR_MAX_W = 64;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/param_mem_if.sv
// Request/response bus of param_mem_ctrl; o_perr exists only when PARAM_MEM_PARITY_EN is defined.
interface param_mem_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    logic              i_req;
    logic              i_op;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic              o_ready;
    logic              o_ack;
    logic              o_rvalid;
    logic [DATA_W-1:0] o_rdata;
    logic              o_err;
`ifdef PARAM_MEM_PARITY_EN
    logic              o_perr;
`endif

    modport master (
        output i_req, i_op, i_addr, i_wdata,
`ifdef PARAM_MEM_PARITY_EN
        input  o_perr,
`endif
        input  o_ready, o_ack, o_rvalid, o_rdata, o_err
    );

    modport slave (
        input  i_req, i_op, i_addr, i_wdata,
`ifdef PARAM_MEM_PARITY_EN
        output o_perr,
`endif
        output o_ready, o_ack, o_rvalid, o_rdata, o_err
    );

endinterface

// File: rtl/param_mem_array.sv
// Register-based word storage with a registered read port; stores an even-parity bit per word
// when PARAM_MEM_PARITY_EN is defined.
module param_mem_array
    import param_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_we,
    input  logic                       i_re,
    input  logic [$clog2(DEPTH)-1:0]   i_addr,
    input  logic [DATA_W-1:0]          i_wdata,
`ifdef PARAM_MEM_PARITY_EN
    output logic                       o_perr,
`endif
    output logic [DATA_W-1:0]          o_rdata
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] rd_word_s;

    // Read mux built as an AND-OR tree so non-power-of-two depths never index past the array.
    always_comb begin
        rd_word_s = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rd_word_s = rd_word_s | (mem_r[i] & {DATA_W{i_addr == ADDR_W'(i)}});
        end
    end

    // Storage words: cleared on reset, single-word write otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_addr == ADDR_W'(i)) begin
                    mem_r[i] <= i_wdata;
                end
            end
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (i_re) begin
            rdata_r <= rd_word_s;
        end
    end

    assign o_rdata = rdata_r;

`ifdef PARAM_MEM_PARITY_EN
    logic par_r [DEPTH];
    logic rd_par_s;
    logic perr_r;

    // Stored parity bit of the addressed word.
    always_comb begin
        rd_par_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_par_s = rd_par_s | (par_r[i] & (i_addr == ADDR_W'(i)));
        end
    end

    // Parity storage written alongside the data word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_r[i] <= 1'b0;
            end
        end else if (i_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_addr == ADDR_W'(i)) begin
                    par_r[i] <= even_parity(PAR_MAX_W'(i_wdata));
                end
            end
        end
    end

    // Mismatch flag is a one-cycle pulse aligned with the loaded read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perr_r <= 1'b0;
        end else begin
            perr_r <= i_re & (even_parity(PAR_MAX_W'(rd_word_s)) != rd_par_s);
        end
    end

    assign o_perr = perr_r;
`endif

endmodule

// File: rtl/param_mem_ctrl.sv
// Req/ack sequenced controller for a DEPTH x DATA_W register memory with range checking.
// Optional per-word parity checking is enabled by defining PARAM_MEM_PARITY_EN.
module param_mem_ctrl
    import param_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    param_mem_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    mem_state_t        state_r;
    mem_state_t        next_state_s;
    logic              op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              in_range_s;
    logic              exec_s;
    logic              we_s;
    logic              re_s;
    logic              ready_r;
    logic              ack_r;
    logic              rvalid_r;
    logic              err_r;
    logic [DATA_W-1:0] rdata_s;

    assign in_range_s = ({1'b0, addr_r} < DEPTH_L);

    // Next-state and array strobes.
    always_comb begin
        next_state_s = state_r;
        exec_s       = 1'b0;
        we_s         = 1'b0;
        re_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.i_req) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: begin
                exec_s       = 1'b1;
                next_state_s = RESP;
                if (in_range_s) begin
                    we_s = (op_r == OP_WRITE);
                    re_s = (op_r == OP_READ);
                end else begin
                    we_s = 1'b0;
                    re_s = 1'b0;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latches; later changes on the bus are ignored until the next acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_r    <= OP_READ;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if ((state_r == IDLE) && bus.i_req) begin
            op_r    <= bus.i_op;
            addr_r  <= bus.i_addr;
            wdata_r <= bus.i_wdata;
        end
    end

    // Response flags are registered at the EXEC->RESP edge, so they pulse for RESP only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ready_r  <= 1'b1;
            ack_r    <= 1'b0;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            ready_r  <= (next_state_s == IDLE);
            ack_r    <= exec_s;
            rvalid_r <= re_s;
            err_r    <= exec_s & ~in_range_s;
        end
    end

    param_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (we_s),
        .i_re    (re_s),
        .i_addr  (addr_r),
        .i_wdata (wdata_r),
`ifdef PARAM_MEM_PARITY_EN
        .o_perr  (bus.o_perr),
`endif
        .o_rdata (rdata_s)
    );

    assign bus.o_ready  = ready_r;
    assign bus.o_ack    = ack_r;
    assign bus.o_rvalid = rvalid_r;
    assign bus.o_rdata  = rdata_s;
`ifdef PARAM_MEM_PARITY_EN
    assign bus.o_err    = err_r | bus.o_perr;
`else
    assign bus.o_err    = err_r;
`endif

endmodule

// File: tb/tb_param_mem_ctrl.sv
// Scoreboard bench for param_mem_ctrl (DEPTH=6 so range errors are reachable);
// parity scenario is compiled only with PARAM_MEM_PARITY_EN.
module tb_param_mem_ctrl;
    import param_mem_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_mem_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    param_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       rvalid;
        logic       err;
        logic       perr;
        logic [7:0] rdata;
        int         cyc;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack pops one expectation; flags outside an ack must stay low.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.o_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(bus.o_ack), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                check({e.name, "_rvalid"}, 32'(bus.o_rvalid), 32'(e.rvalid));
                check({e.name, "_err"}, 32'(bus.o_err), 32'(e.err));
                check({e.name, "_rdata"}, 32'(bus.o_rdata), 32'(e.rdata));
`ifdef PARAM_MEM_PARITY_EN
                check({e.name, "_perr"}, 32'(bus.o_perr), 32'(e.perr));
`endif
            end
        end else begin
            check("stray_pulse", {30'd0, bus.o_rvalid, bus.o_err}, 32'd0);
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (bus.o_ready === 1'b1) return;
            @(negedge clk);
        end
        check("ready_timeout", 32'(bus.o_ready), 32'd1);
    endtask

    // Issue one request at a negedge; optionally poke a second request while busy.
    task automatic issue(input logic op, input logic [2:0] addr, input logic [7:0] wdata,
                         input logic poke, input logic ev, input logic ee, input logic ep,
                         input logic [7:0] ed, input string name);
        exp_t e;
        wait_ready();
        bus.i_req   = 1'b1;
        bus.i_op    = op;
        bus.i_addr  = addr;
        bus.i_wdata = wdata;
        e.rvalid = ev; e.err = ee; e.perr = ep; e.rdata = ed; e.cyc = cyc + 2; e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        bus.i_req   = poke;
        bus.i_op    = OP_WRITE;
        bus.i_addr  = poke ? addr : ~addr;
        bus.i_wdata = poke ? 8'h22 : ~wdata;
        check({name, "_busy_exec"}, 32'(bus.o_ready), 32'd0);
        @(negedge clk);
        bus.i_req = 1'b0;
        check({name, "_busy_resp"}, 32'(bus.o_ready), 32'd0);
        @(negedge clk);
        check({name, "_ready_again"}, 32'(bus.o_ready), 32'd1);
    endtask

    initial begin : stim
        bus.i_req   = 1'b0;
        bus.i_op    = OP_READ;
        bus.i_addr  = 3'd0;
        bus.i_wdata = 8'h00;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_ack", 32'(bus.o_ack), 32'd0);
        check("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);
        check("rst_rdata", 32'(bus.o_rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int a = 0; a < DEPTH; a++) begin
            issue(OP_READ, 3'(a), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "rst_read");
        end

        issue(OP_WRITE, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "wr3");
        issue(OP_READ,  3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, "rd3");

        issue(OP_WRITE, 3'd1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, "busy_wr1");
        issue(OP_READ,  3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, "busy_rd1");

        issue(OP_READ,  3'd7, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, "range_rd7");
        issue(OP_WRITE, 3'd6, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, "range_wr6");
        issue(OP_READ,  3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "intact0");
        issue(OP_READ,  3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, "intact1");
        issue(OP_READ,  3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "intact2");
        issue(OP_READ,  3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, "intact3");
        issue(OP_READ,  3'd4, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "intact4");
        issue(OP_READ,  3'd5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "intact5");

        issue(OP_WRITE, 3'd5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "wr5");
        issue(OP_WRITE, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "wr0");
        issue(OP_READ,  3'd5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, "rd5");
        issue(OP_READ,  3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, "rd0");

        // Reset during EXEC aborts the write and clears the array.
        wait_ready();
        bus.i_req   = 1'b1;
        bus.i_op    = OP_WRITE;
        bus.i_addr  = 3'd2;
        bus.i_wdata = 8'hFF;
        @(negedge clk);
        bus.i_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(bus.o_ready), 32'd1);
        check("midrst_rdata", 32'(bus.o_rdata), 32'd0);
        @(negedge clk);
        issue(OP_READ,  3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "midrst_rd2");
        issue(OP_READ,  3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "midrst_rd3");

        issue(OP_WRITE, 3'd4, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "wr4");
        issue(OP_READ,  3'd4, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, "rd4");
`ifdef PARAM_MEM_PARITY_EN
        dut.u_array.mem_r[4][0] = ~dut.u_array.mem_r[4][0];
        issue(OP_READ,  3'd4, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h76, "par_rd4");
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
